// File: rtl/injection_checker_if.sv
// ============================================================================
// Module   : injection_checker_if
// Purpose  : Run control, DUT/golden samples and result bus for injection_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface injection_checker_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             clear;
  logic             y1;
  logic             y2;
  logic             g1;
  logic             g2;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err1_cnt;
  logic [CNT_W-1:0] err2_cnt;
  logic             first_err_valid;
  logic [CNT_W-1:0] first_err_cyc;
  logic [1:0]       first_err_src;

  modport master (
    output start, clear, y1, y2, g1, g2,
    input  busy, done, pass, err1_cnt, err2_cnt,
           first_err_valid, first_err_cyc, first_err_src
  );

  modport slave (
    input  start, clear, y1, y2, g1, g2,
    output busy, done, pass, err1_cnt, err2_cnt,
           first_err_valid, first_err_cyc, first_err_src
  );
endinterface

`default_nettype wire

// File: rtl/injection_checker.sv
// ============================================================================
// Module   : injection_checker
// Purpose  : Compares DUT outputs against golden outputs over a fixed window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module injection_checker #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16
) (
  input  wire logic            clk,
  input  wire logic            rstn,
  injection_checker_if.slave   chk
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] c_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             w_m1;
  logic             w_m2;
  logic             w_last;
  logic             w_launch;
  logic [CNT_W-1:0] w_err1_nxt;
  logic [CNT_W-1:0] w_err2_nxt;

  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_err1;
  logic [CNT_W-1:0] r_err2;
  logic             r_fev;
  logic [CNT_W-1:0] r_fec;
  logic [1:0]       r_fes;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  assign w_m1     = chk.y1 ^ chk.g1;
  assign w_m2     = chk.y2 ^ chk.g2;
  assign w_last   = (r_cyc == c_LAST);
  assign w_launch = chk.start && !chk.clear && (r_state != S_RUN);

  // Counters stick at all-ones rather than wrapping.
  assign w_err1_nxt = (w_m1 && (r_err1 != c_MAX)) ? r_err1 + 1'b1 : r_err1;
  assign w_err2_nxt = (w_m2 && (r_err2 != c_MAX)) ? r_err2 + 1'b1 : r_err2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (chk.clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (chk.start) w_state_nxt = S_RUN;
        S_RUN:          if (w_last)    w_state_nxt = S_DONE;
        default:                       w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_cyc  <= '0;
      r_err1 <= '0;
      r_err2 <= '0;
      r_fev  <= 1'b0;
      r_fec  <= '0;
      r_fes  <= 2'b00;
    end else begin
      r_busy <= (w_state_nxt == S_RUN);
      r_done <= (w_state_nxt == S_DONE);
      if (chk.clear || w_launch) begin
        r_pass <= 1'b0;
        r_cyc  <= '0;
        r_err1 <= '0;
        r_err2 <= '0;
        r_fev  <= 1'b0;
        r_fec  <= '0;
        r_fes  <= 2'b00;
      end else if (r_state == S_RUN) begin
        r_cyc  <= r_cyc + 1'b1;
        r_err1 <= w_err1_nxt;
        r_err2 <= w_err2_nxt;
        if ((w_m1 || w_m2) && !r_fev) begin
          r_fev <= 1'b1;
          r_fec <= r_cyc;
          r_fes <= {w_m2, w_m1};
        end
        // Verdict uses the final sample's updated counts.
        if (w_last) begin
          r_pass <= (w_err1_nxt == '0) && (w_err2_nxt == '0);
        end
      end
    end
  end

  assign chk.busy            = r_busy;
  assign chk.done            = r_done;
  assign chk.pass            = r_pass;
  assign chk.err1_cnt        = r_err1;
  assign chk.err2_cnt        = r_err2;
  assign chk.first_err_valid = r_fev;
  assign chk.first_err_cyc   = r_fec;
  assign chk.first_err_src   = r_fes;

endmodule

`default_nettype wire

// File: tb/tb_injection_checker.sv
// ============================================================================
// Module   : tb_injection_checker
// Purpose  : Directed self-checking bench for injection_checker (3 configurations).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_injection_checker;

  logic clk;
  logic rstn;
  int   n_tests;
  int   n_fail;

  injection_checker_if #(.CNT_W(8)) ifa ();
  injection_checker_if #(.CNT_W(4)) ifb ();
  injection_checker_if #(.CNT_W(8)) ifc ();

  injection_checker #(.CNT_W(8), .WINDOW(16)) dut_a (.clk(clk), .rstn(rstn), .chk(ifa));
  injection_checker #(.CNT_W(4), .WINDOW(16)) dut_b (.clk(clk), .rstn(rstn), .chk(ifb));
  injection_checker #(.CNT_W(8), .WINDOW(1))  dut_c (.clk(clk), .rstn(rstn), .chk(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ctl(input logic s, input logic c);
    ifa.start = s; ifb.start = s; ifc.start = s;
    ifa.clear = c; ifb.clear = c; ifc.clear = c;
  endtask

  task automatic set_yg(input logic y1, input logic y2, input logic g1, input logic g2);
    ifa.y1 = y1; ifb.y1 = y1; ifc.y1 = y1;
    ifa.y2 = y2; ifb.y2 = y2; ifc.y2 = y2;
    ifa.g1 = g1; ifb.g1 = g1; ifc.g1 = g1;
    ifa.g2 = g2; ifb.g2 = g2; ifc.g2 = g2;
  endtask

  // Start pulse, then 16 indexed samples; sm asserts start during the run.
  task automatic drive_run(input logic [15:0] m1, input logic [15:0] m2,
                           input logic [15:0] sm, output int busy_a, output int busy_c);
    logic [15:0] gp;
    gp = 16'hA5C3;
    busy_a = 0;
    busy_c = 0;
    @(negedge clk);
    set_ctl(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ifa.busy) busy_a++;
      if (ifc.busy) busy_c++;
      set_ctl(sm[i], 1'b0);
      set_yg(gp[i] ^ m1[i], ~gp[i] ^ m2[i], gp[i], ~gp[i]);
    end
    @(negedge clk);
    set_ctl(1'b0, 1'b0);
    set_yg(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    set_ctl(1'b0, 1'b0);
    set_yg(1'b1, 1'b0, 1'b0, 1'b1);
    #23;
    n_tests++; if ({ifa.busy, ifa.done, ifa.pass, ifa.first_err_valid} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {ifa.busy, ifa.done, ifa.pass, ifa.first_err_valid}); end
    n_tests++; if ({ifa.err1_cnt, ifa.err2_cnt, ifa.first_err_cyc, ifa.first_err_src} !== 26'd0) begin n_fail++; $display("FAIL reset_vals: got %h want 0", {ifa.err1_cnt, ifa.err2_cnt, ifa.first_err_cyc, ifa.first_err_src}); end
    @(negedge clk);
    rstn = 1'b1;
    set_yg(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++; if ({ifa.busy, ifa.done, ifc.busy, ifc.done} !== 4'b0000) begin n_fail++; $display("FAIL reset_idle: got %b want 0000", {ifa.busy, ifa.done, ifc.busy, ifc.done}); end
  endtask

  task automatic test_clean_run;
    int ba, bc;
    drive_run(16'h0000, 16'h0000, 16'h0000, ba, bc);
    n_tests++; if (ba !== 16) begin n_fail++; $display("FAIL clean_busy_cycles: got %0d want 16", ba); end
    n_tests++; if ({ifa.busy, ifa.done, ifa.pass} !== 3'b011) begin n_fail++; $display("FAIL clean_flags: got %b want 011", {ifa.busy, ifa.done, ifa.pass}); end
    n_tests++; if ({ifa.err1_cnt, ifa.err2_cnt, ifa.first_err_valid} !== 17'd0) begin n_fail++; $display("FAIL clean_errs: got %h want 0", {ifa.err1_cnt, ifa.err2_cnt, ifa.first_err_valid}); end
    n_tests++; if (bc !== 1 || {ifc.done, ifc.pass} !== 2'b11) begin n_fail++; $display("FAIL w1_clean: got busy=%0d done/pass=%b want 1/11", bc, {ifc.done, ifc.pass}); end
  endtask

  task automatic test_y1_mismatch;
    int ba, bc;
    drive_run(16'h0208, 16'h0000, 16'h0000, ba, bc);
    n_tests++; if (ifa.err1_cnt !== 8'd2 || ifa.err2_cnt !== 8'd0) begin n_fail++; $display("FAIL y1_counts: got %0d/%0d want 2/0", ifa.err1_cnt, ifa.err2_cnt); end
    n_tests++; if (ifa.first_err_cyc !== 8'd3 || ifa.first_err_src !== 2'b01 || ifa.first_err_valid !== 1'b1) begin n_fail++; $display("FAIL y1_first: got cyc=%0d src=%b v=%b want 3/01/1", ifa.first_err_cyc, ifa.first_err_src, ifa.first_err_valid); end
    n_tests++; if ({ifa.done, ifa.pass} !== 2'b10) begin n_fail++; $display("FAIL y1_verdict: got %b want 10", {ifa.done, ifa.pass}); end
  endtask

  task automatic test_both_and_last;
    int ba, bc;
    drive_run(16'h0001, 16'h8001, 16'h0000, ba, bc);
    n_tests++; if (ifa.err1_cnt !== 8'd1 || ifa.err2_cnt !== 8'd2) begin n_fail++; $display("FAIL both_counts: got %0d/%0d want 1/2", ifa.err1_cnt, ifa.err2_cnt); end
    n_tests++; if (ifa.first_err_cyc !== 8'd0 || ifa.first_err_src !== 2'b11) begin n_fail++; $display("FAIL both_first: got cyc=%0d src=%b want 0/11", ifa.first_err_cyc, ifa.first_err_src); end
    n_tests++; if ({ifa.done, ifa.pass} !== 2'b10) begin n_fail++; $display("FAIL both_verdict: got %b want 10", {ifa.done, ifa.pass}); end
    n_tests++; if (ifc.err1_cnt !== 8'd1 || ifc.err2_cnt !== 8'd1 || ifc.first_err_src !== 2'b11 || ifc.pass !== 1'b0) begin n_fail++; $display("FAIL w1_both: got %0d/%0d src=%b pass=%b want 1/1/11/0", ifc.err1_cnt, ifc.err2_cnt, ifc.first_err_src, ifc.pass); end
  endtask

  task automatic test_saturate;
    int ba, bc;
    drive_run(16'hFFFF, 16'h0000, 16'h0000, ba, bc);
    n_tests++; if (ifb.err1_cnt !== 4'd15 || ifb.err2_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_cnt4: got %0d/%0d want 15/0", ifb.err1_cnt, ifb.err2_cnt); end
    n_tests++; if (ifa.err1_cnt !== 8'd16) begin n_fail++; $display("FAIL sat_cnt8: got %0d want 16", ifa.err1_cnt); end
    n_tests++; if ({ifb.done, ifb.pass, ifb.first_err_src} !== 4'b1001) begin n_fail++; $display("FAIL sat_flags: got %b want 1001", {ifb.done, ifb.pass, ifb.first_err_src}); end
  endtask

  task automatic test_reset_midrun;
    int ba, bc;
    @(negedge clk);
    set_ctl(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_ctl(1'b0, 1'b0);
      set_yg(1'b1, 1'b0, 1'b0, 1'b0);
    end
    #2 rstn = 1'b0;
    #1;
    n_tests++; if ({ifa.busy, ifa.done, ifa.first_err_valid} !== 3'b000 || ifa.err1_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_async: got flags=%b err1=%0d want 000/0", {ifa.busy, ifa.done, ifa.first_err_valid}, ifa.err1_cnt); end
    @(negedge clk);
    rstn = 1'b1;
    set_yg(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++; if ({ifa.busy, ifa.done} !== 2'b00) begin n_fail++; $display("FAIL midrst_idle: got %b want 00", {ifa.busy, ifa.done}); end
    drive_run(16'h0000, 16'h0000, 16'h0000, ba, bc);
    n_tests++; if (ba !== 16 || {ifa.done, ifa.pass} !== 2'b11) begin n_fail++; $display("FAIL midrst_rerun: got busy=%0d done/pass=%b want 16/11", ba, {ifa.done, ifa.pass}); end
  endtask

  task automatic test_clear_start;
    int ba, bc;
    drive_run(16'h0001, 16'h0000, 16'h0000, ba, bc);
    @(negedge clk);
    set_ctl(1'b1, 1'b1);
    @(negedge clk);
    set_ctl(1'b0, 1'b0);
    n_tests++; if ({ifa.busy, ifa.done, ifa.pass, ifa.first_err_valid} !== 4'b0000 || ifa.err1_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_start: got flags=%b err1=%0d want 0000/0", {ifa.busy, ifa.done, ifa.pass, ifa.first_err_valid}, ifa.err1_cnt); end
    @(negedge clk);
    n_tests++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL clr_stays_idle: got busy=%b want 0", ifa.busy); end
  endtask

  task automatic test_start_in_run;
    int ba, bc;
    drive_run(16'h0020, 16'h0000, 16'h8104, ba, bc);
    n_tests++; if (ba !== 16 || ifa.done !== 1'b1) begin n_fail++; $display("FAIL run_start_len: got busy=%0d done=%b want 16/1", ba, ifa.done); end
    n_tests++; if (ifa.err1_cnt !== 8'd1 || ifa.first_err_cyc !== 8'd5) begin n_fail++; $display("FAIL run_start_cnt: got err1=%0d cyc=%0d want 1/5", ifa.err1_cnt, ifa.first_err_cyc); end
  endtask

  task automatic test_clear_midrun;
    @(negedge clk);
    set_ctl(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_ctl(1'b0, i == 4);
      set_yg(1'b1, 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    set_ctl(1'b0, 1'b0);
    set_yg(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if ({ifa.busy, ifa.done, ifa.first_err_valid} !== 3'b000 || ifa.err2_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_midrun: got flags=%b err2=%0d want 000/0", {ifa.busy, ifa.done, ifa.first_err_valid}, ifa.err2_cnt); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_clean_run();
    test_y1_mismatch();
    test_both_and_last();
    test_saturate();
    test_reset_midrun();
    test_clear_start();
    test_start_in_run();
    test_clear_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
